exec_stage_mc: RTL and testbench

EXEC_STAGE_MC -- requirements
Module: exec_stage_mc

---
 rtl/exec_stage_mc_if.sv | 41 ++++
 rtl/exec_stage_mc.sv | 151 +++++++++++++++
 tb/tb_exec_stage_mc.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_stage_mc_if.sv
// rtl/exec_stage_mc_if.sv - operand/control bundle and result bundle of the execute stage
interface exec_stage_mc_if;
    logic        flush;
    logic        valid_in;
    logic        is_mul;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        imm;
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic [3:0]  alu_command;
    logic [3:0]  status;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [31:0] val_ra;
    logic [31:0] ex_alu_res;
    logic [31:0] wb_value;
    logic        stall_out;
    logic        valid_out;
    logic [31:0] alu_res;
    logic [31:0] branch_address;
    logic [31:0] val2_out;
    logic [3:0]  status_out;

    modport master (
        output flush, valid_in, is_mul, mem_read_en, mem_write_en, imm,
               sel_src1, sel_src2, alu_command, status, shift_operand, signed_imm,
               pc, val_rn, val_rm, val_ra, ex_alu_res, wb_value,
        input  stall_out, valid_out, alu_res, branch_address, val2_out, status_out
    );

    modport slave (
        input  flush, valid_in, is_mul, mem_read_en, mem_write_en, imm,
               sel_src1, sel_src2, alu_command, status, shift_operand, signed_imm,
               pc, val_rn, val_rm, val_ra, ex_alu_res, wb_value,
        output stall_out, valid_out, alu_res, branch_address, val2_out, status_out
    );
endinterface

// File: rtl/exec_stage_mc.sv
// rtl/exec_stage_mc.sv - execute stage: 1-cycle ALU plus iterative multiplier (EXEC_MLA_EN adds accumulate)
module exec_stage_mc #(
    parameter int MUL_STEP = 4
) (
    input logic           clk,
    input logic           rst,
    exec_stage_mc_if.slave bus
);
    localparam int ITER = 32 / MUL_STEP;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] op1, op2, val2, alu_out;
    logic [31:0] mcand, mplier, acc, acc_init, partial;
    logic [1:0]  mul_cv;
    logic [31:0] addend;
    logic [32:0] sum;
    logic        carry_in, use_adder, flag_c, flag_v;
    logic [4:0]  sh_amt;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
        return (x >> r) | (x << (6'd32 - {1'b0, r}));
    endfunction

    always_comb begin
        case (bus.sel_src1)
            2'd1:    op1 = bus.ex_alu_res;
            2'd2:    op1 = bus.wb_value;
            default: op1 = bus.val_rn;
        endcase
        case (bus.sel_src2)
            2'd1:    op2 = bus.ex_alu_res;
            2'd2:    op2 = bus.wb_value;
            default: op2 = bus.val_rm;
        endcase
    end

    // Memory ops take the raw 12-bit offset; otherwise rotated immediate or shifted register.
    assign sh_amt = bus.shift_operand[11:7];
    always_comb begin
        val2 = op2;
        if (bus.mem_read_en | bus.mem_write_en)
            val2 = {20'b0, bus.shift_operand};
        else if (bus.imm)
            val2 = ror32({24'b0, bus.shift_operand[7:0]}, {bus.shift_operand[11:8], 1'b0});
        else begin
            case (bus.shift_operand[6:5])
                2'd0:    val2 = op2 << sh_amt;
                2'd1:    val2 = op2 >> sh_amt;
                2'd2:    val2 = $unsigned($signed(op2) >>> sh_amt);
                default: val2 = ror32(op2, sh_amt);
            endcase
        end
    end

    // Subtracts run through the adder as op1 + ~val2 + carry so C is the ARM not-borrow.
    always_comb begin
        addend    = val2;
        carry_in  = 1'b0;
        use_adder = 1'b0;
        alu_out   = 32'b0;
        flag_c    = bus.status[1];
        flag_v    = bus.status[0];
        case (bus.alu_command)
            4'b0001: alu_out = val2;
            4'b1001: alu_out = ~val2;
            4'b0010: use_adder = 1'b1;
            4'b0011: begin use_adder = 1'b1; carry_in = bus.status[1]; end
            4'b0100: begin use_adder = 1'b1; addend = ~val2; carry_in = 1'b1; end
            4'b0101: begin use_adder = 1'b1; addend = ~val2; carry_in = bus.status[1]; end
            4'b0110: alu_out = op1 & val2;
            4'b0111: alu_out = op1 | val2;
            4'b1000: alu_out = op1 ^ val2;
            default: alu_out = 32'b0;
        endcase
        sum = {1'b0, op1} + {1'b0, addend} + {32'b0, carry_in};
        if (use_adder) begin
            alu_out = sum[31:0];
            flag_c  = sum[32];
            flag_v  = (op1[31] == addend[31]) & (sum[31] != op1[31]);
        end
    end

`ifdef EXEC_MLA_EN
    assign acc_init = bus.val_ra;
`else
    assign acc_init = 32'b0;
`endif

    assign partial = mcand * {{(32 - MUL_STEP){1'b0}}, mplier[MUL_STEP-1:0]};

    assign bus.stall_out = (state == BUSY) | ((state == IDLE) & bus.valid_in & bus.is_mul);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= 5'd0;
            acc                <= 32'b0;
            mcand              <= 32'b0;
            mplier             <= 32'b0;
            mul_cv             <= 2'b0;
            bus.valid_out      <= 1'b0;
            bus.alu_res        <= 32'b0;
            bus.branch_address <= 32'b0;
            bus.val2_out       <= 32'b0;
            bus.status_out     <= 4'b0;
        end else begin
            bus.valid_out <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.valid_in && bus.is_mul) begin
                            mcand  <= op1;
                            mplier <= op2;
                            acc    <= acc_init;
                            cnt    <= 5'd0;
                            mul_cv <= bus.status[1:0];
                            state  <= BUSY;
                        end else if (bus.valid_in) begin
                            bus.alu_res        <= alu_out;
                            bus.status_out     <= {alu_out[31], alu_out == 32'b0, flag_c, flag_v};
                            bus.val2_out       <= op2;
                            bus.branch_address <= bus.pc + {{6{bus.signed_imm[23]}}, bus.signed_imm, 2'b00};
                            bus.valid_out      <= 1'b1;
                        end
                    end
                    BUSY: begin
                        acc    <= acc + partial;
                        mcand  <= mcand << MUL_STEP;
                        mplier <= mplier >> MUL_STEP;
                        cnt    <= cnt + 5'd1;
                        if (cnt == 5'(ITER - 1))
                            state <= DONE;
                    end
                    DONE: begin
                        bus.alu_res    <= acc;
                        bus.status_out <= {acc[31], acc == 32'b0, mul_cv};
                        bus.valid_out  <= 1'b1;
                        state          <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_exec_stage_mc.sv
// tb/tb_exec_stage_mc.sv - randomized and directed checks of exec_stage_mc against a behavioural model
module tb_exec_stage_mc;
    localparam int MUL_STEP = 4;
    localparam int ITER = 32 / MUL_STEP;
`ifdef EXEC_MLA_EN
    localparam bit MLA = 1'b1;
`else
    localparam bit MLA = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    exec_stage_mc_if bus ();
    exec_stage_mc #(.MUL_STEP(MUL_STEP)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r);
        if (sel == 2'd1) return bus.ex_alu_res;
        if (sel == 2'd2) return bus.wb_value;
        return r;
    endfunction

    function automatic logic [31:0] val2_ref(input logic [31:0] b, input logic [11:0] so,
                                              input logic immf, input logic memf);
        logic [31:0] x;
        int n;
        if (memf) return {20'b0, so};
        if (immf) begin
            x = {24'b0, so[7:0]};
            for (int i = 0; i < 2 * so[11:8]; i++) x = {x[0], x[31:1]};
            return x;
        end
        n = int'(so[11:7]);
        x = b;
        case (so[6:5])
            2'd0: x = b << n;
            2'd1: x = b >> n;
            2'd2: for (int i = 0; i < n; i++) x = {x[31], x[31:1]};
            default: for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
        endcase
        return x;
    endfunction

    task automatic alu_ref(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] st, output logic [31:0] r, output logic [3:0] f);
        longint ua, ub, sa, sb, full, sfull, bor;
        logic c, v;
        ua = {32'b0, a}; ub = {32'b0, b};
        sa = longint'($signed(a)); sb = longint'($signed(b));
        c = st[1]; v = st[0];
        r = 32'b0;
        case (cmd)
            4'b0001: r = b;
            4'b1001: r = ~b;
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            4'b0010, 4'b0011: begin
                full  = ua + ub + ((cmd == 4'b0011) ? longint'(st[1]) : 0);
                sfull = sa + sb + ((cmd == 4'b0011) ? longint'(st[1]) : 0);
                r = full[31:0];
                c = full >= 64'sh1_0000_0000;
                v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
            end
            4'b0100, 4'b0101: begin
                bor   = (cmd == 4'b0101) ? longint'(!st[1]) : 0;
                full  = ua - ub - bor;
                sfull = sa - sb - bor;
                r = full[31:0];
                c = ua >= ub + bor;
                v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
            end
            default: r = 32'b0;
        endcase
        f = {r[31], r == 32'b0, c, v};
    endtask

    task automatic idle_inputs();
        bus.valid_in = 1'b0; bus.is_mul = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic alu_go(input string tag);
        logic [31:0] a, b, v2, r, ba, off;
        logic [3:0]  f;
        a  = fwd(bus.sel_src1, bus.val_rn);
        b  = fwd(bus.sel_src2, bus.val_rm);
        v2 = val2_ref(b, bus.shift_operand, bus.imm, bus.mem_read_en | bus.mem_write_en);
        alu_ref(bus.alu_command, a, v2, bus.status, r, f);
        off = {{8{bus.signed_imm[23]}}, bus.signed_imm};
        ba  = bus.pc + off * 4;
        bus.valid_in = 1'b1; bus.is_mul = 1'b0;
        #1 check({tag, "_stall"}, {31'b0, bus.stall_out}, 32'd0);
        @(posedge clk); @(negedge clk);
        check({tag, "_valid"}, {31'b0, bus.valid_out}, 32'd1);
        check({tag, "_res"}, bus.alu_res, r);
        check({tag, "_nzcv"}, {28'b0, bus.status_out}, {28'b0, f});
        check({tag, "_val2out"}, bus.val2_out, b);
        check({tag, "_baddr"}, bus.branch_address, ba);
        bus.valid_in = 1'b0;
    endtask

    task automatic mul_go(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ra, input logic [3:0] st);
        logic [31:0] p;
        int cycles, stalls;
        p = a * b + (MLA ? ra : 32'b0);
        bus.val_rn = a; bus.val_rm = b; bus.val_ra = ra; bus.status = st;
        bus.sel_src1 = 2'd0; bus.sel_src2 = 2'd0;
        bus.valid_in = 1'b1; bus.is_mul = 1'b1;
        cycles = 0; stalls = 0;
        do begin
            #1;
            if (bus.stall_out) stalls++;
            else idle_inputs();
            @(posedge clk); @(negedge clk);
            cycles++;
        end while (!bus.valid_out && cycles < 100);
        idle_inputs();
        check({tag, "_latency"}, cycles - 1, ITER + 1);
        check({tag, "_stalls"}, stalls, ITER + 1);
        check({tag, "_res"}, bus.alu_res, p);
        check({tag, "_nzcv"}, {28'b0, bus.status_out}, {28'b0, p[31], p == 32'b0, st[1:0]});
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, bus.valid_out}, 32'd0);
        check({tag, "_hold"}, bus.alu_res, p);
    endtask

    task automatic count_valid(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.valid_out) seen++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int cmds[9] = '{1, 9, 2, 3, 4, 5, 6, 7, 8};
        int seen;
        logic [31:0] hold;
        bus.flush = 0; bus.valid_in = 0; bus.is_mul = 0; bus.mem_read_en = 0;
        bus.mem_write_en = 0; bus.imm = 0; bus.sel_src1 = 0; bus.sel_src2 = 0;
        bus.alu_command = 0; bus.status = 0; bus.shift_operand = 0; bus.signed_imm = 0;
        bus.pc = 0; bus.val_rn = 0; bus.val_rm = 0; bus.val_ra = 0;
        bus.ex_alu_res = 0; bus.wb_value = 0;

        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, bus.valid_out}, 32'd0);
        check("rst_res", bus.alu_res, 32'd0);
        check("rst_baddr", bus.branch_address, 32'd0);
        check("rst_val2", bus.val2_out, 32'd0);
        check("rst_status", {28'b0, bus.status_out}, 32'd0);
        check("rst_stall", {31'b0, bus.stall_out}, 32'd0);
        bus.valid_in = 1; bus.is_mul = 1;
        #1 check("rst_stall_mul", {31'b0, bus.stall_out}, 32'd1);
        idle_inputs();
        @(negedge clk) rst = 0;

        // ADD 5+7, plain register operands
        bus.alu_command = 4'b0010; bus.val_rn = 5; bus.val_rm = 7;
        alu_go("add_5_7");

        // forwarding: ex_alu_res - wb_value
        bus.alu_command = 4'b0100; bus.sel_src1 = 2'd1; bus.ex_alu_res = 100;
        bus.sel_src2 = 2'd2; bus.wb_value = 1;
        alu_go("fwd_sub");
        check("fwd_sub_99", bus.alu_res, 32'd99);
        bus.sel_src1 = 0; bus.sel_src2 = 0;

        for (int i = 0; i < 60; i++) begin
            bus.alu_command   = 4'(cmds[$urandom_range(0, 8)]);
            bus.sel_src1      = 2'($urandom_range(0, 3));
            bus.sel_src2      = 2'($urandom_range(0, 3));
            bus.imm           = 1'($urandom_range(0, 1));
            bus.mem_read_en   = ($urandom_range(0, 7) == 0);
            bus.mem_write_en  = ($urandom_range(0, 7) == 0);
            bus.shift_operand = 12'($urandom);
            bus.signed_imm    = 24'($urandom);
            bus.status        = 4'($urandom);
            bus.pc = $urandom; bus.val_rn = $urandom; bus.val_rm = $urandom;
            bus.ex_alu_res = $urandom; bus.wb_value = $urandom;
            alu_go($sformatf("alu_rand%0d", i));
        end
        bus.mem_read_en = 0; bus.mem_write_en = 0; bus.imm = 0; bus.shift_operand = 0;

        mul_go("mul_basic", 32'h0001_0003, 32'h0000_0005, 32'h0, 4'b0000);
        mul_go("mul_zero", 32'h8000_0000, 32'd2, 32'h0, 4'b0011);
        mul_go("mul_zero_cv", 32'h8000_0000, 32'd2, 32'h0, 4'b0010);
        mul_go("mla_3x4", 32'd3, 32'd4, 32'd10, 4'b0000);
        check("mla_3x4_abs", bus.alu_res, MLA ? 32'd22 : 32'd12);
        for (int i = 0; i < 10; i++)
            mul_go($sformatf("mul_rand%0d", i), $urandom, $urandom, $urandom, 4'($urandom));

        // flush in the third BUSY cycle
        hold = bus.alu_res;
        bus.val_rn = 9; bus.val_rm = 9; bus.valid_in = 1; bus.is_mul = 1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        bus.flush = 1; bus.valid_in = 0; bus.is_mul = 0;
        @(posedge clk); @(negedge clk);
        bus.flush = 0;
        check("flush_idle_stall", {31'b0, bus.stall_out}, 32'd0);
        count_valid(12, seen);
        check("flush_no_valid", seen, 0);
        check("flush_hold", bus.alu_res, hold);
        bus.alu_command = 4'b0010; bus.val_rn = 20; bus.val_rm = 22; bus.status = 0;
        alu_go("after_flush");

        // flush beats a simultaneous ALU issue
        hold = bus.alu_res;
        bus.val_rn = 1; bus.val_rm = 1; bus.valid_in = 1; bus.flush = 1;
        @(posedge clk); @(negedge clk);
        idle_inputs();
        check("flush_alu_valid", {31'b0, bus.valid_out}, 32'd0);
        check("flush_alu_hold", bus.alu_res, hold);

        // asynchronous reset mid-multiply
        bus.val_rn = 7; bus.val_rm = 6; bus.valid_in = 1; bus.is_mul = 1;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        #1 rst = 1;
        #1 check("rst_mid_res", bus.alu_res, 32'd0);
        check("rst_mid_baddr", bus.branch_address, 32'd0);
        check("rst_mid_val2", bus.val2_out, 32'd0);
        check("rst_mid_status", {28'b0, bus.status_out}, 32'd0);
        check("rst_mid_stall", {31'b0, bus.stall_out}, 32'd1);
        idle_inputs();
        #1 check("rst_mid_stall_idle", {31'b0, bus.stall_out}, 32'd0);
        @(negedge clk) rst = 0;
        count_valid(15, seen);
        check("rst_mid_no_valid", seen, 0);
        check("rst_mid_res_after", bus.alu_res, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
